// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the multi-port register file
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ADDR_W_MAX = 16;

  // Low bit of port `port` inside a packed bus of `width`-bit lanes.
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

  // True for the architectural zero register; callers zero-extend to ADDR_W_MAX.
  function automatic logic is_zero_addr(input logic [ADDR_W_MAX-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write busy vector, population count and per-port busy lookup
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;
  logic             claim_ok;

  assign claim_ok = claim_en && !((ZERO_REG != 0) && is_zero_addr(ADDR_W_MAX'(claim_addr)));

  // Next busy vector: writes retire producers, a claim names a newer one and so wins.
  always_comb begin
    busy_nxt = busy_q;
    if (wr0_en) busy_nxt[wr0_addr] = 1'b0;
    if (wr1_en) busy_nxt[wr1_addr] = 1'b0;
    if (claim_ok) busy_nxt[claim_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  // Next count tracks bits that flip between the current and next vector.
  always_comb begin
    cnt_nxt = busy_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_nxt[i] && !busy_q[i]) begin
        cnt_nxt = cnt_nxt + CNT_ONE;
      end else if (!busy_nxt[i] && busy_q[i]) begin
        cnt_nxt = cnt_nxt - CNT_ONE;
      end
    end
  end

  // Busy state and its count update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_busy
    logic [ADDR_W-1:0] ra;
    logic              busy_k;
    logic              wr_hit;

    assign ra     = rd_addr[port_lo(k, ADDR_W) +: ADDR_W];
    assign wr_hit = (wr0_en && (wr0_addr == ra)) || (wr1_en && (wr1_addr == ra));

    // A forwarded write hides the stored busy bit unless a claim re-marks it this cycle.
    always_comb begin
      busy_k = busy_q[ra];
      if ((BYPASS != 0) && wr_hit) busy_k = claim_en && (claim_addr == ra);
      if ((ZERO_REG != 0) && is_zero_addr(ADDR_W_MAX'(ra))) busy_k = 1'b0;
      if (rst) busy_k = 1'b0;
    end

    assign rd_busy[k] = busy_k;
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with bypass and pending-write scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr0_ok;
  logic              wr1_ok;

  assign wr0_ok = wr0_en && !((ZERO_REG != 0) && is_zero_addr(ADDR_W_MAX'(wr0_addr)));
  assign wr1_ok = wr1_en && !((ZERO_REG != 0) && is_zero_addr(ADDR_W_MAX'(wr1_addr)));

  // Data array; port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr0_ok) mem[wr0_addr] <= wr0_data;
      if (wr1_ok) mem[wr1_addr] <= wr1_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_data
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data_k;

    assign ra = rd_addr[port_lo(k, ADDR_W) +: ADDR_W];

    // Read mux with optional same-cycle forwarding, wr1 ahead of wr0.
    always_comb begin
      data_k = mem[ra];
      if (BYPASS != 0) begin
        if (wr1_en && (wr1_addr == ra)) begin
          data_k = wr1_data;
        end else if (wr0_en && (wr0_addr == ra)) begin
          data_k = wr0_data;
        end
      end
      if ((ZERO_REG != 0) && is_zero_addr(ADDR_W_MAX'(ra))) data_k = '0;
      if (rst) data_k = '0;
    end

    assign rd_data[port_lo(k, DATA_W) +: DATA_W] = data_k;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_busy    (rd_busy),
    .busy_cnt   (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp in bypass/zero and plain configurations
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [4:0]  ra0;
  logic [4:0]  ra1;
  logic [9:0]  rd_addr;
  logic        wr0_en;
  logic [4:0]  wr0_addr;
  logic [31:0] wr0_data;
  logic        wr1_en;
  logic [4:0]  wr1_addr;
  logic [31:0] wr1_data;
  logic        claim_en;
  logic [4:0]  claim_addr;

  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [5:0]  busy_cnt_a;
  logic [63:0] rd_data_b;
  logic [1:0]  rd_busy_b;
  logic [5:0]  busy_cnt_b;

  int n_chk;
  int n_pass;

  assign rd_addr = {ra1, ra0};

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_cnt(busy_cnt_a)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_cnt(busy_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
    logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
    logic        ce;  logic [4:0] ca;
    logic [4:0]  ra0; logic [4:0] ra1;
    logic [31:0] a_d0; logic a_b0; logic [31:0] a_d1; logic a_b1; logic [5:0] a_cnt;
    logic [31:0] b_d0; logic b_b0; logic [31:0] b_d1; logic b_b1; logic [5:0] b_cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                       input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                       input logic ce, input logic [4:0] ca,
                       input logic [4:0] r0, input logic [4:0] r1);
    wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
    wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
    claim_en = ce; claim_addr = ca;
    ra0 = r0; ra1 = r1;
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    idle(5'd0, 5'd0);

    //        w0e   w0a    w0d           w1e   w1a    w1d           ce    ca     ra0    ra1     A: d0 b0 d1 b1 cnt                              B: d0 b0 d1 b1 cnt
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd31,  32'h0,        1'b0, 32'h0,        1'b0, 6'd0, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd5,   32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd5,   32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0};
    vecs[3]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,       1'b0, 5'd0,  5'd7,  5'd5,   32'h22,       1'b0, 32'hDEADBEEF, 1'b0, 6'd0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 6'd0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd5,   32'h22,       1'b0, 32'hDEADBEEF, 1'b0, 6'd0, 32'h22,       1'b0, 32'hDEADBEEF, 1'b0, 6'd0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd7,   32'h0,        1'b0, 32'h22,       1'b0, 6'd0, 32'h0,        1'b0, 32'h22,       1'b0, 6'd0};
    vecs[6]  = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd3,   32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1, 6'd1, 32'h0,        1'b1, 32'h0,        1'b1, 6'd1};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h5A5A5A5A, 1'b0, 5'd0,  5'd3,  5'd3,   32'h5A5A5A5A, 1'b0, 32'h5A5A5A5A, 1'b0, 6'd1, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1, 6'd1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd7,   32'h5A5A5A5A, 1'b0, 32'h22,       1'b0, 6'd0, 32'h5A5A5A5A, 1'b0, 32'h22,       1'b0, 6'd0};
    vecs[9]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,   32'h0,        1'b0, 32'h0,        1'b0, 6'd0, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,   32'h0,        1'b0, 32'h0,        1'b0, 6'd0, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 6'd1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  5'd0,  5'd0,   32'h0,        1'b0, 32'h0,        1'b0, 6'd0, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 6'd1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,   32'h0,        1'b0, 32'h0,        1'b0, 6'd0, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 6'd0};
    vecs[13] = '{1'b1, 5'd10, 32'h100,      1'b1, 5'd11, 32'h200,      1'b1, 5'd12, 5'd10, 5'd11,  32'h100,      1'b0, 32'h200,      1'b0, 6'd0, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd13, 5'd12, 5'd10,  32'h0,        1'b1, 32'h100,      1'b0, 6'd1, 32'h0,        1'b1, 32'h100,      1'b0, 6'd1};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 5'd13, 5'd11,  32'h0,        1'b1, 32'h200,      1'b0, 6'd2, 32'h0,        1'b1, 32'h200,      1'b0, 6'd2};
    vecs[16] = '{1'b1, 5'd12, 32'h300,      1'b1, 5'd13, 32'h400,      1'b0, 5'd0,  5'd12, 5'd13,  32'h300,      1'b0, 32'h400,      1'b0, 6'd2, 32'h0,        1'b1, 32'h0,        1'b1, 6'd2};
    vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd13,  32'h300,      1'b0, 32'h400,      1'b0, 6'd0, 32'h300,      1'b0, 32'h400,      1'b0, 6'd0};

    // Reset state: every address reads zero and not busy.
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      idle(5'(a), 5'(31 - a));
      #1;
      chk($sformatf("rst_a_d0[%0d]", a), rd_data_a[31:0], 32'h0);
      chk($sformatf("rst_a_b[%0d]", a), 32'(rd_busy_a), 32'h0);
      chk($sformatf("rst_b_d0[%0d]", a), rd_data_b[31:0], 32'h0);
      chk($sformatf("rst_b_b[%0d]", a), 32'(rd_busy_b), 32'h0);
    end
    chk("rst_a_cnt", 32'(busy_cnt_a), 32'h0);
    chk("rst_b_cnt", 32'(busy_cnt_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table: outputs sampled mid-cycle, before the edge that commits the row.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].w0e, vecs[i].w0a, vecs[i].w0d, vecs[i].w1e, vecs[i].w1a, vecs[i].w1d,
            vecs[i].ce, vecs[i].ca, vecs[i].ra0, vecs[i].ra1);
      #1;
      chk($sformatf("v%0d_a_d0", i), rd_data_a[31:0], vecs[i].a_d0);
      chk($sformatf("v%0d_a_b0", i), 32'(rd_busy_a[0]), 32'(vecs[i].a_b0));
      chk($sformatf("v%0d_a_d1", i), rd_data_a[63:32], vecs[i].a_d1);
      chk($sformatf("v%0d_a_b1", i), 32'(rd_busy_a[1]), 32'(vecs[i].a_b1));
      chk($sformatf("v%0d_a_cnt", i), 32'(busy_cnt_a), 32'(vecs[i].a_cnt));
      chk($sformatf("v%0d_b_d0", i), rd_data_b[31:0], vecs[i].b_d0);
      chk($sformatf("v%0d_b_b0", i), 32'(rd_busy_b[0]), 32'(vecs[i].b_b0));
      chk($sformatf("v%0d_b_d1", i), rd_data_b[63:32], vecs[i].b_d1);
      chk($sformatf("v%0d_b_b1", i), 32'(rd_busy_b[1]), 32'(vecs[i].b_b1));
      chk($sformatf("v%0d_b_cnt", i), 32'(busy_cnt_b), 32'(vecs[i].b_cnt));
    end

    // Build up state: claims on 1, 2, 4 and a write to 9.
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd0, 5'd0);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd0, 5'd0);
    @(negedge clk); drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
    @(negedge clk); idle(5'd9, 5'd1);
    #1;
    chk("pre_rst_a_d9", rd_data_a[31:0], 32'h99);
    chk("pre_rst_a_b1", 32'(rd_busy_a[1]), 32'h1);
    chk("pre_rst_a_cnt", 32'(busy_cnt_a), 32'd3);
    chk("pre_rst_b_cnt", 32'(busy_cnt_b), 32'd3);

    // Mid-cycle reset with a write and claim still presented.
    drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd9, 5'd1);
    #1;
    chk("byp_a_d9", rd_data_a[31:0], 32'h55);
    #1;
    rst = 1'b1;
    #1;
    chk("in_rst_a_d9", rd_data_a[31:0], 32'h0);
    chk("in_rst_a_b1", 32'(rd_busy_a[1]), 32'h0);
    chk("in_rst_a_cnt", 32'(busy_cnt_a), 32'h0);
    chk("in_rst_b_d9", rd_data_b[31:0], 32'h0);
    chk("in_rst_b_cnt", 32'(busy_cnt_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(5'd9, 5'd5);
    #1;
    chk("post_rst_a_d9", rd_data_a[31:0], 32'h0);
    chk("post_rst_a_b5", 32'(rd_busy_a[1]), 32'h0);
    chk("post_rst_a_cnt", 32'(busy_cnt_a), 32'h0);
    chk("post_rst_b_d9", rd_data_b[31:0], 32'h0);
    chk("post_rst_b_b5", 32'(rd_busy_b[1]), 32'h0);
    chk("post_rst_b_cnt", 32'(busy_cnt_b), 32'h0);

    // First edge after reset release performs normal work.
    drive(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd9, 5'd2);
    @(negedge clk);
    idle(5'd9, 5'd2);
    #1;
    chk("first_a_d9", rd_data_a[31:0], 32'h77);
    chk("first_a_b2", 32'(rd_busy_a[1]), 32'h1);
    chk("first_a_cnt", 32'(busy_cnt_a), 32'd1);
    chk("first_b_d9", rd_data_b[31:0], 32'h77);
    chk("first_b_b2", 32'(rd_busy_b[1]), 32'h1);
    chk("first_b_cnt", 32'(busy_cnt_b), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
